geri_yaz_hakem: RTL

- Round-robin arbiter for the single integer register-file write port, shared by `ISTEKCI_SAYISI` execution-unit result sources (e.g. ALU, memory, mul/div).
- Sits between the execution units and `geri_yaz`/register file.
- Each cycle it grants at most one valid requester and registers the winner onto the write port.
- Writes to x0 are consumed but dropped; there is a flush input and a saturating contention counter for performance analysis.

---
 rtl/geri_yaz_hakem.sv | 118 +++++++++++
 1 files changed

// File: rtl/geri_yaz_hakem.sv
// geri_yaz_hakem: round-robin arbiter for the single integer register-file
// write port. Several execution-unit result sources compete for the port.
// Each cycle this block picks at most one winner and registers its result
// onto the write port. Writes to x0 are accepted but not performed.
// A saturating counter records how many cycles had contention.
module geri_yaz_hakem #(
    parameter int ISTEKCI_SAYISI = 3,
    parameter int VERI_BIT       = 32,
    parameter int YAZMAC_BIT     = 5,
    parameter int UOP_TAG_BIT    = 6
) (
    input  logic                                  clk_i,
    input  logic                                  rstn_i,
    input  logic [ISTEKCI_SAYISI-1:0]             ist_gecerli_i,
    input  logic [ISTEKCI_SAYISI*VERI_BIT-1:0]    ist_veri_i,
    input  logic [ISTEKCI_SAYISI*YAZMAC_BIT-1:0]  ist_adres_i,
    input  logic [ISTEKCI_SAYISI*UOP_TAG_BIT-1:0] ist_etiket_i,
    output logic [ISTEKCI_SAYISI-1:0]             ist_hazir_o,
    input  logic                                  bosalt_i,
    output logic [VERI_BIT-1:0]                   yo_veri_o,
    output logic [YAZMAC_BIT-1:0]                 yo_adres_o,
    output logic [UOP_TAG_BIT-1:0]                yo_etiket_o,
    output logic                                  yo_gecerli_o,
    output logic [31:0]                           cakisma_sayisi_o
);

    localparam int N  = ISTEKCI_SAYISI;
    localparam int IW = $clog2(N);

    typedef logic [IW-1:0] idx_t;

    idx_t                   oncelik_r;
    idx_t                   kazanan;
    logic                   aktarim;
    logic [N-1:0]           hazir;
    logic [IW:0]            aday;
    idx_t                   sonraki_oncelik;
    logic [VERI_BIT-1:0]    kazanan_veri;
    logic [YAZMAC_BIT-1:0]  kazanan_adres;
    logic [UOP_TAG_BIT-1:0] kazanan_etiket;
    logic                   cakisma_var;

    logic [VERI_BIT-1:0]    yo_veri_r;
    logic [YAZMAC_BIT-1:0]  yo_adres_r;
    logic [UOP_TAG_BIT-1:0] yo_etiket_r;
    logic                   yo_gecerli_r;
    logic [31:0]            cakisma_r;

    // Scan requesters from the priority pointer upward with wrap and pick the first valid one.
    always_comb begin
        // NOTE: every variable gets a default before the scan so no path leaves it unassigned (no latch).
        hazir   = '0;
        kazanan = '0;
        aktarim = 1'b0;
        aday    = '0;
        for (int k = 0; k < N; k++) begin
            aday = {1'b0, oncelik_r} + (IW+1)'(k);
            if (aday >= (IW+1)'(N)) begin
                aday = aday - (IW+1)'(N);
            end
            if (!aktarim && ist_gecerli_i[aday[IW-1:0]]) begin
                aktarim = 1'b1;
                kazanan = aday[IW-1:0];
            end
        end
        // A flush suppresses the grant. The pointer therefore stays where it was.
        if (bosalt_i) begin
            aktarim = 1'b0;
        end
        if (aktarim) begin
            hazir[kazanan] = 1'b1;
        end
    end

    // While reset is held, no requester may believe it was accepted.
    assign ist_hazir_o = rstn_i ? hazir : '0;

    assign kazanan_veri    = ist_veri_i[int'(kazanan)*VERI_BIT +: VERI_BIT];
    assign kazanan_adres   = ist_adres_i[int'(kazanan)*YAZMAC_BIT +: YAZMAC_BIT];
    assign kazanan_etiket  = ist_etiket_i[int'(kazanan)*UOP_TAG_BIT +: UOP_TAG_BIT];
    assign sonraki_oncelik = (kazanan == idx_t'(N-1)) ? '0 : kazanan + idx_t'(1);

    // Contention means at least two valid bits are set. Clearing the lowest set bit then leaves something.
    assign cakisma_var = ((ist_gecerli_i & (ist_gecerli_i - N'(1))) != '0) && !bosalt_i;

    // Register the winning result. Advance the pointer past the winner. Count contention cycles.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            oncelik_r    <= '0;
            yo_veri_r    <= '0;
            yo_adres_r   <= '0;
            yo_etiket_r  <= '0;
            yo_gecerli_r <= 1'b0;
            cakisma_r    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (aktarim) begin
                yo_veri_r    <= kazanan_veri;
                yo_adres_r   <= kazanan_adres;
                yo_etiket_r  <= kazanan_etiket;
                yo_gecerli_r <= (kazanan_adres != '0);
                oncelik_r    <= sonraki_oncelik;
            end else begin
                yo_gecerli_r <= 1'b0;
            end
            if (cakisma_var && (cakisma_r != '1)) begin
                cakisma_r <= cakisma_r + 32'd1;
            end
        end
    end

    assign yo_veri_o        = yo_veri_r;
    assign yo_adres_o       = yo_adres_r;
    assign yo_etiket_o      = yo_etiket_r;
    assign yo_gecerli_o     = yo_gecerli_r;
    assign cakisma_sayisi_o = cakisma_r;

endmodule
